// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: FSM state type,
// default sizing constants and a ceiling-log2 helper.
package sc_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DIMENSION = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Windowed ones counter: counts valid samples and ones over 2^WIDTH samples,
// flagging the completing sample and presenting the window total combinationally.
module sc_ones_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           sample,
  input  logic           bit_in,
  output logic           done,
  output logic [WIDTH:0] total
);

  logic [WIDTH-1:0] sample_cnt;
  logic [WIDTH:0]   acc;

  // A sample arriving with clear is discarded, so it can never complete a window.
  assign done  = sample && !clear && (sample_cnt == '1);
  assign total = acc + (WIDTH+1)'(bit_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt <= '0;
      acc        <= '0;
    end else if (clear || done) begin
      sample_cnt <= '0;
      acc        <= '0;
    end else if (sample) begin
      sample_cnt <= sample_cnt + 1'b1;
      acc        <= acc + (WIDTH+1)'(bit_in);
    end
  end

endmodule

// File: rtl/sc_window_accumulator.sv
// Counts ones over back-to-back windows of 2^WIDTH valid samples and presents
// each count (and its DIMENSION-rescaled value) through a valid/ready register.
module sc_window_accumulator
  import sc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DIMENSION = DEF_DIMENSION,
  parameter int unsigned LOG_DIM   = clogb2(DIMENSION)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in,
  input  logic                   in_valid,
  input  logic                   restart,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH:0]         count,
  output logic [WIDTH+LOG_DIM:0] scaled,
  output logic                   overrun
);

  state_t         state;
  logic           done;
  logic [WIDTH:0] total;
  logic           load;

  sc_ones_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (restart),
    .sample (in_valid),
    .bit_in (in),
    .done   (done),
    .total  (total)
  );

  // A pending result is replaced only if it is being accepted this same cycle.
  assign load = done && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      count     <= '0;
      scaled    <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (in_valid && !restart) state <= ACCUM;
        ACCUM:   if (restart) state <= IDLE;
        default: state <= IDLE;
      endcase

      overrun <= done && out_valid && !out_ready;

      if (load) begin
        out_valid <= 1'b1;
        count     <= total;
        scaled    <= (WIDTH+LOG_DIM+1)'(total) << LOG_DIM;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sc_window_accumulator.md
# sc_window_accumulator

Downstream stage of `sc_dot_product`. It consumes the 1-bit stochastic result stream and its `valid` qualifier, and counts ones over fixed windows of 2^WIDTH valid samples. It emits each window's binary count, plus the count rescaled by DIMENSION to undo the mux-adder's 1/DIMENSION scaling, through a valid/ready output register. It replaces ad-hoc last-bit framing ahead of binary post-processing.

## Interface
- `WIDTH`, 8: log2 of window length; the window is 2^WIDTH valid samples.
- `DIMENSION`, 4: dot-product dimension, a power of two ≥ 2; `LOG_DIM` = clog2(DIMENSION) is derived.
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `in` input, 1: stochastic result bit.
- `in_valid` input, 1: `in` is a sample this cycle.
- `restart` input, 1: abandon the current window (synchronous).
- `out_ready` input, 1: downstream accepts `count`/`scaled`.
- `out_valid` output, 1: output register holds an unaccepted result.
- `count` output, WIDTH+1: number of ones in the window, range 0..2^WIDTH.
- `scaled` output, WIDTH+1+LOG_DIM: `count << LOG_DIM`.
- `overrun` output, 1: one-cycle pulse when a completed window is dropped.

## Operation
- FSM states: IDLE, ACCUM.
  - IDLE: accumulator = 0, sample counter = 0. A cycle with `in_valid`=1 counts that sample and moves the FSM to ACCUM.
  - ACCUM: each `in_valid`=1 cycle increments the sample counter and adds `in` to the accumulator. `in_valid`=0 cycles stall both counters. No timeout.
- Window completes on the valid sample that makes the sample count 2^WIDTH.
  - Final count = accumulator + `in`.
  - Accumulator and sample counter clear.
  - The FSM stays in ACCUM, so windows run back-to-back with no dead cycle.
- Output register: on completion, if `out_valid`=0 or `out_ready`=1, load `count`/`scaled` and set `out_valid`=1.
  - Otherwise drop the new result, keep the old one, and pulse `overrun`.
- Handshake: a transfer occurs on a cycle with `out_valid`=1 and `out_ready`=1. After a transfer, `out_valid` clears unless a new window completes in the same cycle. In that case the new result loads and `out_valid` stays 1.
- `restart`=1 clears the accumulator and sample counter and returns the FSM to IDLE.
  - A sample presented in the same cycle is discarded, even if it would have completed a window. No result and no overrun are produced.
  - `restart` does not touch the output register or `out_valid`.
- Width rules: the accumulator is WIDTH+1 bits and never wraps (max 2^WIDTH). The sample counter is WIDTH bits; completion is detected at all-ones with `in_valid`. `scaled` is a zero-filled left shift with no rounding.

## Timing
- Reset values:
  - FSM = IDLE, accumulator = 0, sample counter = 0.
  - `out_valid`=0, `count`=0, `scaled`=0, `overrun`=0.
- Latency: `out_valid`, `count`, `scaled` update on the clock edge that samples the window's final bit, so they are visible the following cycle.
- `overrun` is registered and asserts for exactly one cycle after that same edge.
- Outputs are held stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-window clears everything immediately and asynchronously. The partial window is lost.
- Minimum window period is 2^WIDTH cycles. Output throughput is one result per window when `out_ready` is held high.

## Structure
- Shared package `sc_pkg`: `clogb2` function, FSM state typedef (IDLE/ACCUM), default WIDTH/DIMENSION constants.
- One sub-module, `sc_ones_counter`: windowed ones/sample counter with `clear` and `done`. The top module holds the FSM, output register and handshake.

## Test plan
- All-ones stream, `in_valid`=1 for 256 cycles, `out_ready`=1 → one `out_valid` pulse with `count`=256, `scaled`=1024.
- Alternating 1,0 for 256 valid cycles, with `in_valid` deasserted every third cycle → `count`=128, `scaled`=512. The result appears the cycle after the 256th valid sample.
- Two back-to-back all-zero windows, `out_ready`=1 → two results of `count`=0, 256 cycles apart, no gap in accumulation.
- `out_ready`=0 across two windows (first all ones, second all zeros) → `count` stays 256, `overrun` pulses one cycle at the end of window 2.
  - Then raise `out_ready` → one transfer, `out_valid` drops.
- `restart` pulsed at sample 100 of an all-ones window, then 256 more ones → single result `count`=256. Pending `out_valid` is unaffected by `restart`.
- Assert `rst` low for 1 cycle at sample 200 with a result pending → all outputs 0 immediately. The next full window of 64 ones + 192 zeros gives `count`=64, `scaled`=256.
